// File: rtl/scoreboard_hazard_unit_if.sv
// ID-stage hazard bundle: decode-side request fields and stall/debug results.
// master = decode stage driving ID fields; slave = scoreboard_hazard_unit.
interface scoreboard_hazard_unit_if #(
  parameter int REG_AW = 3,
  parameter int CNT_W  = 16
);
  logic                   valid_ID;
  logic                   flush_ID;
  logic [REG_AW-1:0]      Rs_ID;
  logic [REG_AW-1:0]      Rt_ID;
  logic                   Rs_used_ID;
  logic                   Rt_used_ID;
  logic [REG_AW-1:0]      Write_register_ID;
  logic                   RegWrite_ID;
  logic                   MemRead_ID;
  logic                   stall;
  logic                   stall_rs;
  logic                   stall_rt;
  logic [2**REG_AW-1:0]   busy_vec;
  logic [CNT_W-1:0]       stall_count;

  modport master (
    output valid_ID, flush_ID,
    output Rs_ID, Rt_ID,
    output Rs_used_ID, Rt_used_ID,
    output Write_register_ID,
    output RegWrite_ID, MemRead_ID,
    input  stall, stall_rs, stall_rt,
    input  busy_vec, stall_count
  );

  modport slave (
    input  valid_ID, flush_ID,
    input  Rs_ID, Rt_ID,
    input  Rs_used_ID, Rt_used_ID,
    input  Write_register_ID,
    input  RegWrite_ID, MemRead_ID,
    output stall, stall_rs, stall_rt,
    output busy_vec, stall_count
  );
endinterface

// File: rtl/scoreboard_hazard_unit.sv
// Countdown-scoreboard RAW hazard detector for ID (clk, rst async low, sb slave).
// Outputs stall/stall_rs/stall_rt combinationally; busy_vec and stall_count for debug.
module scoreboard_hazard_unit #(
  parameter int REG_AW    = 3,
  parameter int WB_DIST   = 3,
  parameter int FWD_EN    = 0,
  parameter int FWD_SLACK = 1,
  parameter int CNT_W     = 16
) (
  input logic clk,
  input logic rst,
  scoreboard_hazard_unit_if.slave sb
);
  localparam int NUM_REGS = 2**REG_AW;
  localparam int CW = $clog2(WB_DIST + 1);
  localparam logic [CW-1:0] LOAD_CNT = CW'(WB_DIST);
  localparam logic [CW-1:0] SLACK = CW'(FWD_SLACK);
  localparam logic [CW-1:0] ONE = CW'(1);
  localparam bit FWD = (FWD_EN != 0);

  logic [CW-1:0]       cnt [NUM_REGS];
  logic [NUM_REGS-1:0] is_load;
  logic [NUM_REGS-1:0] busy;
  logic [CNT_W-1:0]    stall_q;
  logic haz_rs;
  logic haz_rt;
  logic stall;
  logic issue;

  // With forwarding only an unfinished load can block a reader.
  function automatic logic hazard(
    input logic [CW-1:0] c,
    input logic          ld
  );
    return FWD ? (ld && (c > SLACK))
               : (c != '0);
  endfunction

  assign haz_rs = sb.valid_ID & sb.Rs_used_ID &
    hazard(cnt[sb.Rs_ID], is_load[sb.Rs_ID]);
  assign haz_rt = sb.valid_ID & sb.Rt_used_ID &
    hazard(cnt[sb.Rt_ID], is_load[sb.Rt_ID]);

  assign sb.stall_rs = haz_rs & ~sb.flush_ID;
  assign sb.stall_rt = haz_rt & ~sb.flush_ID;
  assign stall = (haz_rs | haz_rt) & ~sb.flush_ID;
  assign sb.stall = stall;

  assign issue = sb.valid_ID & ~stall & ~sb.flush_ID;

  always_comb begin
    busy = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      busy[r] = (cnt[r] != '0);
    end
  end

  assign sb.busy_vec = busy;
  assign sb.stall_count = stall_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt[r] <= '0;
      end
      is_load <= '0;
      stall_q <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        // A new write wins over draining, so WAW restarts the count.
        if (issue && sb.RegWrite_ID &&
            sb.Write_register_ID == REG_AW'(r)) begin
          cnt[r]     <= LOAD_CNT;
          is_load[r] <= sb.MemRead_ID;
        end else if (cnt[r] != '0) begin
          cnt[r] <= cnt[r] - ONE;
          if (cnt[r] == ONE) begin
            is_load[r] <= 1'b0;
          end
        end
      end
      if (stall && (stall_q != '1)) begin
        stall_q <= stall_q + 1'b1;
      end
    end
  end
endmodule
